opregister_master: RTL

Command sequencer that drives the control side of a 4-bit operation register (data, write enable, output enable, 2-bit op select) and reads the result back. It accepts one command per valid/ready handshake: optional load, N op-clock applications, readback. The captured value is returned on a valid/ready response channel. It sits between a test/host controller and one opregister instance, and is the only agent driving that register's inputs.

---
 rtl/opregister_master_if.sv | 82 ++++++++
 rtl/opregister_master.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/opregister_master_if.sv
// ---------------------------------------------------------------------------
// opregister_master_if
//
// Bundles every signal that opregister_master exchanges with the outside
// world except clock and reset:
//   - command channel  (host -> sequencer, valid/ready)
//   - register control (sequencer -> opregister data/we/oe/opsel, and the
//                       register output coming back)
//   - response channel (sequencer -> host, valid/ready)
//   - busy status
//
// Signal names keep the sequencer's point of view: i_w_* are driven into the
// sequencer, o_w_* are driven by it.
//
// Modports:
//   master : the sequencer itself (opregister_master)
//   slave  : the environment around it (host controller + register)
// ---------------------------------------------------------------------------
interface opregister_master_if #(
   parameter int P_CNT_W = 3
);

   // command channel
   logic               i_w_cmd_valid;
   logic               o_w_cmd_ready;
   logic               i_w_cmd_load;
   logic [3:0]         i_w_cmd_data;
   logic [1:0]         i_w_cmd_opsel;
   logic [P_CNT_W-1:0] i_w_cmd_count;

   // operation register control side
   logic [3:0]         o_w_reg_data;
   logic               o_w_reg_we;
   logic               o_w_reg_oe;
   logic [1:0]         o_w_reg_opsel;
   logic [3:0]         i_w_reg_out;

   // response channel
   logic               o_w_rsp_valid;
   logic               i_w_rsp_ready;
   logic [3:0]         o_w_rsp_data;

   // status
   logic               o_w_busy;

   modport master (
      input  i_w_cmd_valid,
      output o_w_cmd_ready,
      input  i_w_cmd_load,
      input  i_w_cmd_data,
      input  i_w_cmd_opsel,
      input  i_w_cmd_count,
      output o_w_reg_data,
      output o_w_reg_we,
      output o_w_reg_oe,
      output o_w_reg_opsel,
      input  i_w_reg_out,
      output o_w_rsp_valid,
      input  i_w_rsp_ready,
      output o_w_rsp_data,
      output o_w_busy
   );

   modport slave (
      output i_w_cmd_valid,
      input  o_w_cmd_ready,
      output i_w_cmd_load,
      output i_w_cmd_data,
      output i_w_cmd_opsel,
      output i_w_cmd_count,
      input  o_w_reg_data,
      input  o_w_reg_we,
      input  o_w_reg_oe,
      input  o_w_reg_opsel,
      output i_w_reg_out,
      input  o_w_rsp_valid,
      output i_w_rsp_ready,
      input  o_w_rsp_data,
      input  o_w_busy
   );

endinterface

// File: rtl/opregister_master.sv
// ---------------------------------------------------------------------------
// opregister_master
//
// Command sequencer for a 4-bit operation register. Each accepted command
// optionally loads a value, applies the selected op for a given number of
// clocks, then reads the register back and returns the captured value on a
// valid/ready response channel.
//
// Ports:
//   i_w_clk    : clock, all state changes on the rising edge
//   i_w_reset  : synchronous active-high reset
//   bus        : opregister_master_if.master
//                  cmd  : i_w_cmd_valid / o_w_cmd_ready, load, data, opsel, count
//                  reg  : o_w_reg_data, o_w_reg_we, o_w_reg_oe, o_w_reg_opsel,
//                         i_w_reg_out
//                  rsp  : o_w_rsp_valid / i_w_rsp_ready, o_w_rsp_data
//                  o_w_busy
//
// Parameters:
//   P_HOLD_SEL : op-select code that leaves the register unchanged
//   P_CNT_W    : width of the op-repeat count (must match the interface)
//
// Sequence of states per command:
//   IDLE -> [LOAD] -> [OP x count] -> READ -> RESP -> IDLE
//
// Register-side outputs are registered: they are set at the same edge that
// enters the state they belong to, so each state's controls are valid for
// exactly the cycle(s) the FSM sits in that state. cmd_ready and busy are
// pure decodes of the state register.
// ---------------------------------------------------------------------------
module opregister_master #(
   parameter logic [1:0] P_HOLD_SEL = 2'b00,
   parameter int         P_CNT_W    = 3
) (
   input  logic                 i_w_clk,
   input  logic                 i_w_reset,
   opregister_master_if.master  bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_OP,
      ST_READ,
      ST_RESP
   } state_t;

   localparam logic [P_CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [P_CNT_W-1:0] CNT_ONE  = P_CNT_W'(1);

   state_t             state;

   // command fields still needed after the accepting edge
   logic [1:0]         lat_opsel;
   logic [P_CNT_W-1:0] lat_count;

   // remaining op clocks while in OP
   logic [P_CNT_W-1:0] op_cnt;

   // registered outputs
   logic [3:0]         reg_data_q;
   logic               reg_we_q;
   logic               reg_oe_q;
   logic [1:0]         reg_opsel_q;
   logic               rsp_valid_q;
   logic [3:0]         rsp_data_q;

   logic               cmd_ready;

   assign cmd_ready = (state == ST_IDLE);

   always_ff @(posedge i_w_clk) begin
      if (i_w_reset) begin
         state       <= ST_IDLE;
         lat_opsel   <= P_HOLD_SEL;
         lat_count   <= CNT_ZERO;
         op_cnt      <= CNT_ZERO;
         reg_data_q  <= 4'h0;
         reg_we_q    <= 1'b0;
         reg_oe_q    <= 1'b0;
         reg_opsel_q <= P_HOLD_SEL;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 4'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               // fields are only sampled on an actual handshake
               if (bus.i_w_cmd_valid && cmd_ready) begin
                  lat_opsel <= bus.i_w_cmd_opsel;
                  lat_count <= bus.i_w_cmd_count;
                  if (bus.i_w_cmd_load) begin
                     state      <= ST_LOAD;
                     reg_we_q   <= 1'b1;
                     reg_data_q <= bus.i_w_cmd_data;
                  end else if (bus.i_w_cmd_count != CNT_ZERO) begin
                     state       <= ST_OP;
                     reg_opsel_q <= bus.i_w_cmd_opsel;
                     op_cnt      <= bus.i_w_cmd_count;
                  end else begin
                     state    <= ST_READ;
                     reg_oe_q <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               reg_we_q   <= 1'b0;
               reg_data_q <= 4'h0;
               if (lat_count != CNT_ZERO) begin
                  state       <= ST_OP;
                  reg_opsel_q <= lat_opsel;
                  op_cnt      <= lat_count;
               end else begin
                  state    <= ST_READ;
                  reg_oe_q <= 1'b1;
               end
            end

            ST_OP: begin
               // counter holds the number of op clocks left including this
               // one; at 1 this is the last op edge, so leave for READ
               op_cnt <= op_cnt - CNT_ONE;
               if (op_cnt == CNT_ONE) begin
                  state       <= ST_READ;
                  reg_opsel_q <= P_HOLD_SEL;
                  reg_oe_q    <= 1'b1;
               end
            end

            ST_READ: begin
               state       <= ST_RESP;
               reg_oe_q    <= 1'b0;
               rsp_data_q  <= bus.i_w_reg_out;
               rsp_valid_q <= 1'b1;
            end

            ST_RESP: begin
               // rsp_data_q is left untouched so it stays stable until the
               // next READ overwrites it
               if (bus.i_w_rsp_ready) begin
                  state       <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end

            default: begin
               state       <= ST_IDLE;
               op_cnt      <= CNT_ZERO;
               reg_data_q  <= 4'h0;
               reg_we_q    <= 1'b0;
               reg_oe_q    <= 1'b0;
               reg_opsel_q <= P_HOLD_SEL;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_w_cmd_ready = cmd_ready;
   assign bus.o_w_busy      = (state != ST_IDLE);
   assign bus.o_w_reg_data  = reg_data_q;
   assign bus.o_w_reg_we    = reg_we_q;
   assign bus.o_w_reg_oe    = reg_oe_q;
   assign bus.o_w_reg_opsel = reg_opsel_q;
   assign bus.o_w_rsp_valid = rsp_valid_q;
   assign bus.o_w_rsp_data  = rsp_data_q;

endmodule
